// File: rtl/matrix_pkg.sv
// -----------------------------------------------------------------------------
// matrix_pkg
// Shared definitions for the 16x16 LED matrix front end.
//   MATRIX_ROWS / MATRIX_COLS : matrix geometry
//   frame_t                   : flat ROWS*COLS frame vector, row r at
//                               bits [r*COLS +: COLS], bit 0 of a row is
//                               the leftmost column
//   row_t                     : one row word
//   buf_state_t               : double-buffer FSM state
// -----------------------------------------------------------------------------
package matrix_pkg;

    localparam int MATRIX_ROWS = 16;
    localparam int MATRIX_COLS = 16;

    typedef logic [MATRIX_ROWS*MATRIX_COLS-1:0] frame_t;
    typedef logic [MATRIX_COLS-1:0]             row_t;

    typedef enum logic {
        FILL    = 1'b0,
        PENDING = 1'b1
    } buf_state_t;

endpackage : matrix_pkg

// File: rtl/frame_sync_gen.sv
// -----------------------------------------------------------------------------
// frame_sync_gen
// Free-running row counter that models a scanner advancing one row per
// clock. It wraps at ROWS-1 and flags the last row, which is the cycle
// before the scanner returns to row 0.
// Ports:
//   clock   in  rising-edge clock
//   reset_n in  asynchronous active-low reset (counter clears to 0)
//   sync    out high while the counter equals ROWS-1
// -----------------------------------------------------------------------------
module frame_sync_gen #(
    parameter int ROWS  = 16,
    parameter int ROW_W = 4
) (
    input  logic clock,
    input  logic reset_n,
    output logic sync
);

    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

    logic [ROW_W-1:0] row_cnt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            row_cnt <= '0;
        end else if (row_cnt == LAST_ROW) begin
            row_cnt <= '0;
        end else begin
            row_cnt <= row_cnt + 1'b1;
        end
    end

    assign sync = (row_cnt == LAST_ROW);

endmodule : frame_sync_gen

// File: rtl/frame_double_buffer.sv
// -----------------------------------------------------------------------------
// frame_double_buffer
// Double-buffered frame store feeding the row-scanned LED matrix driver.
// Rows are written into a back buffer; a commit publishes the whole back
// buffer to the displayed front buffer at the next scan-frame boundary,
// so the matrix never shows a torn frame.
//
// Build option FRAME_SYNC_GEN_EN: when defined, the frame_sync input is
// ignored and an internal row counter (frame_sync_gen) supplies the frame
// boundary. The port list is the same in both builds.
//
// Ports:
//   clock         in   rising-edge clock
//   reset_n       in   asynchronous active-low reset
//   wr_valid      in   row write request
//   wr_ready      out  row write can be accepted (FILL state)
//   wr_row        in   back-buffer row index
//   wr_data       in   row bits, bit 0 = leftmost column, 1 = LED on
//   commit_valid  in   request to publish the back buffer
//   commit_ready  out  commit can be accepted (FILL state)
//   frame_sync    in   pulse from the scanner at the start of row 0
//   mat           out  registered front buffer, row r at [r*COLS +: COLS]
//   swap_pulse    out  one-cycle pulse after the front buffer is updated
//   swap_count    out  number of completed swaps, wraps 255 -> 0
//
// Handshakes: a transfer happens on every rising edge where valid and
// ready are both high. ready does not depend on valid, and the requester
// holds its payload stable until the transfer edge.
// -----------------------------------------------------------------------------
module frame_double_buffer
    import matrix_pkg::*;
#(
    parameter int ROWS  = MATRIX_ROWS,
    parameter int COLS  = MATRIX_COLS,
    parameter int ROW_W = 4
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [ROW_W-1:0]      wr_row,
    input  logic [COLS-1:0]       wr_data,
    input  logic                  commit_valid,
    output logic                  commit_ready,
    input  logic                  frame_sync,
    output logic [ROWS*COLS-1:0]  mat,
    output logic                  swap_pulse,
    output logic [7:0]            swap_count
);

    buf_state_t            state_q;
    buf_state_t            state_d;

    logic [COLS-1:0]       back [ROWS];
    logic [ROWS*COLS-1:0]  front;

    logic                  sync_evt;
    logic                  do_swap;
    logic                  wr_fire;
    logic                  row_ok;

    // ---------------------------------------------------------------------
    // Frame boundary source
    // ---------------------------------------------------------------------
`ifdef FRAME_SYNC_GEN_EN
    logic unused_frame_sync;
    assign unused_frame_sync = frame_sync;

    frame_sync_gen #(
        .ROWS  (ROWS),
        .ROW_W (ROW_W)
    ) u_frame_sync_gen (
        .clock   (clock),
        .reset_n (reset_n),
        .sync    (sync_evt)
    );
`else
    // Rising-edge detect so a frame_sync held for several cycles counts
    // as one boundary; a commit made while the pulse is still high waits
    // for the next pulse.
    logic frame_sync_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            frame_sync_q <= 1'b0;
        end else begin
            frame_sync_q <= frame_sync;
        end
    end

    assign sync_evt = frame_sync & ~frame_sync_q;
`endif

    // ---------------------------------------------------------------------
    // FSM
    // ---------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        wr_ready     = 1'b0;
        commit_ready = 1'b0;
        do_swap      = 1'b0;
        case (state_q)
            FILL: begin
                wr_ready     = 1'b1;
                commit_ready = 1'b1;
                // A boundary in the commit cycle itself is not used; the
                // swap waits for the following one.
                if (commit_valid) begin
                    state_d = PENDING;
                end
            end
            PENDING: begin
                if (sync_evt) begin
                    do_swap = 1'b1;
                    state_d = FILL;
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Buffers
    // ---------------------------------------------------------------------
    assign wr_fire = wr_valid & wr_ready;
    // Out-of-range rows complete the handshake but are discarded.
    assign row_ok  = (int'(wr_row) < ROWS);

    // Back keeps its contents after a swap so later edits are incremental.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < ROWS; r++) begin
                back[r] <= '0;
            end
        end else if (wr_fire && row_ok) begin
            back[wr_row] <= wr_data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            front      <= '0;
            swap_pulse <= 1'b0;
            swap_count <= 8'd0;
        end else begin
            swap_pulse <= do_swap;
            if (do_swap) begin
                for (int r = 0; r < ROWS; r++) begin
                    front[r*COLS +: COLS] <= back[r];
                end
                swap_count <= swap_count + 8'd1;
            end
        end
    end

    assign mat = front;

endmodule : frame_double_buffer

// File: tb/tb_frame_double_buffer.sv
// -----------------------------------------------------------------------------
// tb_frame_double_buffer
// Directed bench for frame_double_buffer. A back-buffer model snapshots the
// expected frame into exp_q at each commit; the frame is popped and compared
// with mat when swap_pulse appears. Build with FRAME_SYNC_GEN_EN defined to
// exercise the internal frame-boundary generator instead.
// -----------------------------------------------------------------------------
module tb_frame_double_buffer;

  localparam int ROWS  = 16;
  localparam int COLS  = 16;
  localparam int ROW_W = 4;
  localparam int FW    = ROWS * COLS;

  // clock / reset
  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  logic             wr_valid;
  logic             wr_ready;
  logic [ROW_W-1:0] wr_row;
  logic [COLS-1:0]  wr_data;
  logic             commit_valid;
  logic             commit_ready;
  logic             frame_sync;
  logic [FW-1:0]    mat;
  logic             swap_pulse;
  logic [7:0]       swap_count;

  frame_double_buffer #(
    .ROWS  (ROWS),
    .COLS  (COLS),
    .ROW_W (ROW_W)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_row       (wr_row),
    .wr_data      (wr_data),
    .commit_valid (commit_valid),
    .commit_ready (commit_ready),
    .frame_sync   (frame_sync),
    .mat          (mat),
    .swap_pulse   (swap_pulse),
    .swap_count   (swap_count)
  );

  // scoreboard
  logic [FW-1:0]   exp_q[$];
  logic [COLS-1:0] m_back [ROWS];
  logic            m_pend;
  logic [7:0]      exp_count;
  int unsigned     n_checks = 0;
  int unsigned     n_fail   = 0;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [FW-1:0] pack_back();
    logic [FW-1:0] f;
    f = '0;
    for (int r = 0; r < ROWS; r++) f[r*COLS +: COLS] = m_back[r];
    return f;
  endfunction

  task automatic model_clear();
    for (int r = 0; r < ROWS; r++) m_back[r] = '0;
    exp_q.delete();
    m_pend    = 1'b0;
    exp_count = 8'd0;
  endtask

  // driver: one clock cycle of stimulus; the model tracks what the DUT
  // should accept from its own notion of FILL/PENDING
  task automatic drive(input logic wv, input logic [ROW_W-1:0] row, input logic [COLS-1:0] data,
                       input logic cv, input logic fs);
    wr_valid     = wv;
    wr_row       = row;
    wr_data      = data;
    commit_valid = cv;
    frame_sync   = fs;
    if (wv && !m_pend && int'(row) < ROWS) m_back[row] = data;
    if (cv && !m_pend) begin
      exp_q.push_back(pack_back());
      m_pend = 1'b1;
    end
    tick();
    wr_valid     = 1'b0;
    commit_valid = 1'b0;
    frame_sync   = 1'b0;
  endtask

  // compare swap_pulse against expectation; on a swap pop the frame
  task automatic check_swap(input string tag, input logic expect_swap);
    logic [FW-1:0] f;
    check({tag, "_pulse"}, FW'(swap_pulse), FW'(expect_swap));
    if (expect_swap) begin
      check({tag, "_qsize"}, FW'(exp_q.size()), FW'(1));
      if (exp_q.size() > 0) begin
        f = exp_q.pop_front();
        check({tag, "_mat"}, mat, f);
      end
      exp_count = exp_count + 8'd1;
      m_pend    = 1'b0;
      check({tag, "_ready"}, FW'(wr_ready), FW'(1));
    end
    check({tag, "_count"}, FW'(swap_count), FW'(exp_count));
  endtask

  task automatic do_reset();
    reset_n      = 1'b0;
    wr_valid     = 1'b0;
    wr_row       = '0;
    wr_data      = '0;
    commit_valid = 1'b0;
    frame_sync   = 1'b0;
    model_clear();
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

`ifdef FRAME_SYNC_GEN_EN
  // advance with frame_sync held high (must be ignored) until swap_pulse
  task automatic wait_swap(input int budget, inout int cyc);
    int waited;
    waited = 0;
    while (swap_pulse !== 1'b1 && waited < budget) begin
      drive(1'b0, '0, '0, 1'b0, 1'b1);
      cyc++;
      waited++;
    end
  endtask
`endif

  initial begin
    logic [FW-1:0]   prev;
    logic [COLS-1:0] d;
    int              cyc;

    do_reset();
    check("rst_mat",    mat, '0);
    check("rst_pulse",  FW'(swap_pulse), FW'(0));
    check("rst_count",  FW'(swap_count), FW'(0));
    check("rst_wready", FW'(wr_ready), FW'(1));
    check("rst_cready", FW'(commit_ready), FW'(1));

`ifdef FRAME_SYNC_GEN_EN
    cyc = 0;
    repeat (3) begin
      drive(1'b0, '0, '0, 1'b0, 1'b1);
      cyc++;
    end
    drive(1'b1, 4'd2, 16'h0F0F, 1'b1, 1'b1);
    cyc++;
    check("gen_pending", FW'(wr_ready), FW'(0));
    wait_swap(40, cyc);
    check("gen_swap_cycle", FW'(cyc), FW'(16));
    check_swap("gen_first", 1'b1);
    repeat (255) begin
      drive(1'b0, '0, '0, 1'b1, 1'b1);
      wait_swap(20, cyc);
      check_swap("gen_wrap", 1'b1);
    end
    check("gen_wrap_zero", FW'(swap_count), FW'(0));
`else
    // row 0 written and committed, no frame boundary yet
    drive(1'b1, 4'd0, 16'h8001, 1'b0, 1'b0);
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    check("t1_wready",  FW'(wr_ready), FW'(0));
    check("t1_cready",  FW'(commit_ready), FW'(0));
    check("t1_mat",     mat, '0);
    repeat (3) drive(1'b0, '0, '0, 1'b0, 1'b0);
    check("t1_hold",    mat, '0);
    check_swap("t1_nosync", 1'b0);

    // boundary performs the swap
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    check_swap("t2", 1'b1);
    check("t2_row0", FW'(mat[0 +: COLS]), FW'(16'h8001));
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    check("t2_pulse_off", FW'(swap_pulse), FW'(0));

    // all rows back to back, commit with row 15
    for (int r = 0; r < ROWS; r++) begin
      d = (r == ROWS - 1) ? 16'hFFFF : COLS'($urandom_range(0, 16'hFFFF));
      drive(1'b1, ROW_W'(r), d, (r == ROWS - 1), 1'b0);
    end
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    check_swap("t3", 1'b1);
    check("t3_row15", FW'(mat[240 +: COLS]), FW'(16'hFFFF));

    // boundary while FILL does nothing
    prev = mat;
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    check_swap("t4_fill_sync", 1'b0);
    check("t4_mat", mat, prev);

    // commit and boundary in the same cycle: swap waits
    drive(1'b1, 4'd3, 16'hA5A5, 1'b1, 1'b1);
    check_swap("t5_same", 1'b0);
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    check_swap("t5_idle", 1'b0);
    check("t5_mat_held", mat, prev);
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    check_swap("t5_next", 1'b1);

    // wide boundary pulse counts once
    drive(1'b1, 4'd7, 16'h00C3, 1'b1, 1'b0);
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    check_swap("t6_first", 1'b1);
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    check_swap("t6_second", 1'b0);
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    check_swap("t6_third", 1'b0);

    // write attempt while PENDING is refused
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    check("t7_wready", FW'(wr_ready), FW'(0));
    drive(1'b1, 4'd5, 16'h1234, 1'b0, 1'b0);
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    check_swap("t7", 1'b1);

    // reset mid-PENDING discards commit and clears both buffers
    drive(1'b1, 4'd1, 16'hBEEF, 1'b0, 1'b0);
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    check("t8_mat",    mat, '0);
    check("t8_count",  FW'(swap_count), FW'(0));
    check("t8_wready", FW'(wr_ready), FW'(1));
    model_clear();
    @(negedge clock);
    reset_n = 1'b1;
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    check_swap("t8_after", 1'b1);

    // 255 further swaps: counter wraps to 0
    repeat (255) begin
      drive(1'b0, '0, '0, 1'b1, 1'b0);
      drive(1'b0, '0, '0, 1'b0, 1'b1);
      check_swap("t9_wrap", 1'b1);
    end
    check("t9_wrap_zero", FW'(swap_count), FW'(0));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_frame_double_buffer
